mem_stage_hs: RTL and testbench

//  Parametrised MEM pipeline stage for the pipelined ARM CPU. Issues loads/stores to a

---
 rtl/mem_stage_hs_if.sv | 33 +++
 rtl/mem_stage_hs.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// rtl/mem_stage_hs_if.sv - data-memory request/response bus for the MEM stage
//
// Purpose: bundles the req/rvalid handshake between the MEM stage (master)
//          and a variable-latency data memory (slave).
// Signals:
//   mem_req    master->slave  one-cycle request pulse
//   mem_we     master->slave  request is a write
//   mem_addr   master->slave  request address
//   mem_wdata  master->slave  store data, right-justified
//   mem_size   master->slave  access size (00 byte .. 11 double)
//   mem_rvalid slave->master  read data valid / write ack
//   mem_rdata  slave->master  read data, right-justified
interface mem_stage_hs_if #(
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM pipeline stage with variable-latency memory handshake
//
// Purpose: issues loads/stores over a req/rvalid handshake, stalls upstream
//          while an access is outstanding, sizes/extends load data and
//          registers the writeback controls and results for the WB stage.
// Ports:
//   clk, reset (sync, active-low)
//   valid_in, mem_read_in, mem_write_in, reg_write_in, memtoreg_in,
//   st_fwd_sel, size_in, sign_ext_in, wreg_in, alu_result_in,
//   store_data_in, fwd_data_in          : instruction from EX
//   mem (master modport)                 : data-memory bus
//   stall_out                            : freeze IF..EX
//   valid_out, reg_write_out, memtoreg_out, wreg_out,
//   alu_result_out, mem_result_out       : registered WB-stage payload
//   err_out                              : sticky access-timeout flag
// DATA_W must be at least 64 so that every access size fits.
module mem_stage_hs #(
  parameter int DATA_W  = 64,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              memtoreg_in,
  input  logic              st_fwd_sel,
  input  logic [1:0]        size_in,
  input  logic              sign_ext_in,
  input  logic [REG_W-1:0]  wreg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [DATA_W-1:0] fwd_data_in,
  mem_stage_hs_if.master    mem,
  output logic              stall_out,
  output logic              valid_out,
  output logic              reg_write_out,
  output logic              memtoreg_out,
  output logic [REG_W-1:0]  wreg_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] mem_result_out,
  output logic              err_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state_q, state_d;

  // Request fields latched at issue; upstream is frozen but we do not rely on it.
  logic              lat_we_q,        lat_we_d;
  logic [1:0]        lat_size_q,      lat_size_d;
  logic              lat_sx_q,        lat_sx_d;
  logic              lat_reg_write_q, lat_reg_write_d;
  logic              lat_memtoreg_q,  lat_memtoreg_d;
  logic [REG_W-1:0]  lat_wreg_q,      lat_wreg_d;
  logic [DATA_W-1:0] lat_alu_q,       lat_alu_d;
  logic [CNT_W-1:0]  cnt_q,           cnt_d;

  logic              valid_q,         valid_d;
  logic              reg_write_q,     reg_write_d;
  logic              memtoreg_q,      memtoreg_d;
  logic [REG_W-1:0]  wreg_q,          wreg_d;
  logic [DATA_W-1:0] alu_result_q,    alu_result_d;
  logic [DATA_W-1:0] mem_result_q,    mem_result_d;
  logic              err_q,           err_d;

  logic mem_op;
  logic rsp_ok;
  logic timeout_hit;

  assign mem_op      = valid_in & (mem_read_in | mem_write_in);
  assign rsp_ok      = (state_q == S_WAIT) & mem.mem_rvalid;
  // Fires on the TIMEOUT-th WAIT cycle that sees no response.
  assign timeout_hit = (state_q == S_WAIT) & ~mem.mem_rvalid &
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  function automatic logic [DATA_W-1:0] size_extend(
    input logic [DATA_W-1:0] d,
    input logic [1:0]        sz,
    input logic              sx
  );
    logic [DATA_W-1:0] r;
    case (sz)
      2'b00:   r = {{(DATA_W-8){sx & d[7]}},   d[7:0]};
      2'b01:   r = {{(DATA_W-16){sx & d[15]}}, d[15:0]};
      2'b10:   r = {{(DATA_W-32){sx & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      lat_we_q        <= 1'b0;
      lat_size_q      <= 2'b00;
      lat_sx_q        <= 1'b0;
      lat_reg_write_q <= 1'b0;
      lat_memtoreg_q  <= 1'b0;
      lat_wreg_q      <= '0;
      lat_alu_q       <= '0;
      cnt_q           <= '0;
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      memtoreg_q      <= 1'b0;
      wreg_q          <= '0;
      alu_result_q    <= '0;
      mem_result_q    <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      lat_we_q        <= lat_we_d;
      lat_size_q      <= lat_size_d;
      lat_sx_q        <= lat_sx_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_memtoreg_q  <= lat_memtoreg_d;
      lat_wreg_q      <= lat_wreg_d;
      lat_alu_q       <= lat_alu_d;
      cnt_q           <= cnt_d;
      valid_q         <= valid_d;
      reg_write_q     <= reg_write_d;
      memtoreg_q      <= memtoreg_d;
      wreg_q          <= wreg_d;
      alu_result_q    <= alu_result_d;
      mem_result_q    <= mem_result_d;
      err_q           <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_op) state_d = S_WAIT;
      S_WAIT:  if (rsp_ok || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational outputs: request issue and stall.
  always_comb begin
    mem.mem_req   = (state_q == S_IDLE) & mem_op;
    mem.mem_we    = (state_q == S_IDLE) & mem_op & mem_write_in;
    mem.mem_addr  = alu_result_in;
    mem.mem_size  = size_in;
    mem.mem_wdata = st_fwd_sel ? fwd_data_in : store_data_in;
    if (state_q == S_IDLE) stall_out = mem_op;
    else                   stall_out = ~mem.mem_rvalid;
  end

  // Datapath next-values. Default is a bubble to WB; other payload holds.
  always_comb begin
    lat_we_d        = lat_we_q;
    lat_size_d      = lat_size_q;
    lat_sx_d        = lat_sx_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_memtoreg_d  = lat_memtoreg_q;
    lat_wreg_d      = lat_wreg_q;
    lat_alu_d       = lat_alu_q;
    cnt_d           = cnt_q;
    valid_d         = 1'b0;
    reg_write_d     = 1'b0;
    memtoreg_d      = memtoreg_q;
    wreg_d          = wreg_q;
    alu_result_d    = alu_result_q;
    mem_result_d    = mem_result_q;
    err_d           = err_q;

    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          lat_we_d        = mem_write_in;
          lat_size_d      = size_in;
          lat_sx_d        = sign_ext_in;
          lat_reg_write_d = reg_write_in;
          lat_memtoreg_d  = memtoreg_in;
          lat_wreg_d      = wreg_in;
          lat_alu_d       = alu_result_in;
          cnt_d           = '0;
        end else if (valid_in) begin
          valid_d      = 1'b1;
          reg_write_d  = reg_write_in;
          memtoreg_d   = memtoreg_in;
          wreg_d       = wreg_in;
          alu_result_d = alu_result_in;
          mem_result_d = '0;
        end
      end
      S_WAIT: begin
        if (rsp_ok) begin
          valid_d      = 1'b1;
          reg_write_d  = lat_reg_write_q;
          memtoreg_d   = lat_memtoreg_q;
          wreg_d       = lat_wreg_q;
          alu_result_d = lat_alu_q;
          mem_result_d = lat_we_q ? '0
                                  : size_extend(mem.mem_rdata, lat_size_q, lat_sx_q);
        end else if (timeout_hit) begin
          // Abandoned access still retires so the pipeline drains, but never writes a register.
          valid_d      = 1'b1;
          reg_write_d  = 1'b0;
          memtoreg_d   = lat_memtoreg_q;
          wreg_d       = lat_wreg_q;
          alu_result_d = lat_alu_q;
          mem_result_d = '0;
          err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign valid_out      = valid_q;
  assign reg_write_out  = reg_write_q;
  assign memtoreg_out   = memtoreg_q;
  assign wreg_out       = wreg_q;
  assign alu_result_out = alu_result_q;
  assign mem_result_out = mem_result_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - directed self-checking bench for mem_stage_hs
module tb_mem_stage_hs;

  localparam int DATA_W  = 64;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in, mem_read_in, mem_write_in, reg_write_in, memtoreg_in;
  logic              st_fwd_sel, sign_ext_in;
  logic [1:0]        size_in;
  logic [REG_W-1:0]  wreg_in;
  logic [DATA_W-1:0] alu_result_in, store_data_in, fwd_data_in;
  logic              stall_out, valid_out, reg_write_out, memtoreg_out, err_out;
  logic [REG_W-1:0]  wreg_out;
  logic [DATA_W-1:0] alu_result_out, mem_result_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_hs_if #(.DATA_W(DATA_W)) mif ();

  mem_stage_hs #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .memtoreg_in(memtoreg_in), .st_fwd_sel(st_fwd_sel),
    .size_in(size_in), .sign_ext_in(sign_ext_in), .wreg_in(wreg_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .fwd_data_in(fwd_data_in),
    .mem(mif.master),
    .stall_out(stall_out), .valid_out(valid_out), .reg_write_out(reg_write_out),
    .memtoreg_out(memtoreg_out), .wreg_out(wreg_out), .alu_result_out(alu_result_out),
    .mem_result_out(mem_result_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; memtoreg_in = 0;
    st_fwd_sel = 0; sign_ext_in = 0; size_in = 2'b00; wreg_in = '0;
    alu_result_in = '0; store_data_in = '0; fwd_data_in = '0;
  endtask

  task automatic drive_load(input logic [1:0] sz, input logic sx,
                            input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] addr);
    valid_in = 1; mem_read_in = 1; mem_write_in = 0; reg_write_in = 1; memtoreg_in = 1;
    st_fwd_sel = 0; size_in = sz; sign_ext_in = sx; wreg_in = wr; alu_result_in = addr;
  endtask

  task automatic test_reset();
    drive_idle();
    mif.mem_rvalid = 0; mif.mem_rdata = '0;
    reset = 0;
    tick(); tick();
    reset = 1;
    #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_checks++; if (reg_write_out !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %b expected 0", reg_write_out); end
    n_checks++; if (alu_result_out !== 64'h0) begin n_fail++; $display("FAIL reset_alu: got %h expected 0", alu_result_out); end
    n_checks++; if (mem_result_out !== 64'h0) begin n_fail++; $display("FAIL reset_mem_result: got %h expected 0", mem_result_out); end
    n_checks++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_out); end
    n_checks++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mif.mem_req); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
  endtask

  task automatic test_alu_op();
    drive_idle();
    valid_in = 1; reg_write_in = 1; wreg_in = 5'd3; alu_result_in = 64'h40;
    #1;
    n_checks++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL alu_no_req: got %b expected 0", mif.mem_req); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", stall_out); end
    tick();
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b expected 1", valid_out); end
    n_checks++; if (alu_result_out !== 64'h40) begin n_fail++; $display("FAIL alu_result: got %h expected 40", alu_result_out); end
    n_checks++; if (wreg_out !== 5'd3) begin n_fail++; $display("FAIL alu_wreg: got %0d expected 3", wreg_out); end
    n_checks++; if (reg_write_out !== 1'b1) begin n_fail++; $display("FAIL alu_reg_write: got %b expected 1", reg_write_out); end
    n_checks++; if (mem_result_out !== 64'h0) begin n_fail++; $display("FAIL alu_mem_result: got %h expected 0", mem_result_out); end
    drive_idle();
    tick();
    n_checks++; if (valid_out !== 1'b0 || reg_write_out !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got valid=%b rw=%b expected 0 0", valid_out, reg_write_out); end
  endtask

  task automatic test_load_byte_sext();
    int stalls = 0;
    drive_load(2'b00, 1'b1, 5'd5, 64'h100);
    #1;
    n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0) begin n_fail++; $display("FAIL lb_req: got req=%b we=%b expected 1 0", mif.mem_req, mif.mem_we); end
    n_checks++; if (mif.mem_addr !== 64'h100 || mif.mem_size !== 2'b00) begin n_fail++; $display("FAIL lb_addr: got %h/%b expected 100/00", mif.mem_addr, mif.mem_size); end
    if (stall_out === 1'b1) stalls++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall_out === 1'b1) stalls++;
      n_checks++; if (mif.mem_req !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL lb_wait%0d: got req=%b valid=%b expected 0 0", i, mif.mem_req, valid_out); end
    end
    tick();
    mif.mem_rvalid = 1; mif.mem_rdata = 64'h1234_5678_9ABC_DE80;
    #1;
    if (stall_out === 1'b1) stalls++;
    n_checks++; if (stalls !== 4) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d expected 4", stalls); end
    tick();
    mif.mem_rvalid = 0;
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL lb_valid: got %b expected 1", valid_out); end
    n_checks++; if (mem_result_out !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffffffffffff80", mem_result_out); end
    n_checks++; if (wreg_out !== 5'd5 || alu_result_out !== 64'h100) begin n_fail++; $display("FAIL lb_ctrl: got wreg=%0d alu=%h expected 5 100", wreg_out, alu_result_out); end
    drive_idle();
    tick();
  endtask

  task automatic test_store_fwd();
    int valids = 0;
    drive_idle();
    valid_in = 1; mem_write_in = 1; st_fwd_sel = 1; fwd_data_in = 64'hDEAD;
    store_data_in = 64'h1111; size_in = 2'b11; alu_result_in = 64'h200;
    #1;
    n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin n_fail++; $display("FAIL st_req: got req=%b we=%b expected 1 1", mif.mem_req, mif.mem_we); end
    n_checks++; if (mif.mem_wdata !== 64'hDEAD) begin n_fail++; $display("FAIL st_wdata: got %h expected dead", mif.mem_wdata); end
    tick();
    mif.mem_rvalid = 1; mif.mem_rdata = 64'hFFFF;
    #1;
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL st_stall_release: got %b expected 0", stall_out); end
    tick();
    mif.mem_rvalid = 0;
    drive_idle();
    if (valid_out === 1'b1) valids++;
    n_checks++; if (mem_result_out !== 64'h0 || alu_result_out !== 64'h200) begin n_fail++; $display("FAIL st_result: got mem=%h alu=%h expected 0 200", mem_result_out, alu_result_out); end
    tick();
    if (valid_out === 1'b1) valids++;
    tick();
    if (valid_out === 1'b1) valids++;
    n_checks++; if (valids !== 1) begin n_fail++; $display("FAIL st_valid_once: got %0d expected 1", valids); end
  endtask

  task automatic test_timeout();
    int edges = 0;
    bit done = 0;
    drive_load(2'b10, 1'b0, 5'd7, 64'h300);
    while (!done && edges < 40) begin
      tick();
      edges++;
      if (valid_out === 1'b1) done = 1;
    end
    drive_idle();
    #1;
    n_checks++; if (!done || edges !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got done=%0d edges=%0d expected %0d", done, edges, TIMEOUT + 1); end
    n_checks++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", err_out); end
    n_checks++; if (reg_write_out !== 1'b0 || mem_result_out !== 64'h0) begin n_fail++; $display("FAIL to_outputs: got rw=%b mem=%h expected 0 0", reg_write_out, mem_result_out); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL to_stall: got %b expected 0", stall_out); end
    tick(); tick(); tick();
    n_checks++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", err_out); end
  endtask

  task automatic test_reset_mid_wait();
    drive_load(2'b11, 1'b0, 5'd9, 64'h500);
    tick();
    tick();
    drive_idle();
    reset = 0;
    tick();
    reset = 1;
    mif.mem_rvalid = 1; mif.mem_rdata = 64'hAB;
    #1;
    n_checks++; if (err_out !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_wait_clear: got err=%b valid=%b expected 0 0", err_out, valid_out); end
    n_checks++; if (alu_result_out !== 64'h0 || wreg_out !== 5'd0) begin n_fail++; $display("FAIL rst_wait_regs: got alu=%h wreg=%0d expected 0 0", alu_result_out, wreg_out); end
    n_checks++; if (stall_out !== 1'b0 || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_spurious_comb: got stall=%b req=%b expected 0 0", stall_out, mif.mem_req); end
    tick();
    mif.mem_rvalid = 0;
    n_checks++; if (valid_out !== 1'b0 || mem_result_out !== 64'h0) begin n_fail++; $display("FAIL rst_spurious_reg: got valid=%b mem=%h expected 0 0", valid_out, mem_result_out); end
  endtask

  task automatic test_back_to_back();
    int reqs = 0;
    drive_load(2'b10, 1'b0, 5'd8, 64'h400);
    #1;
    if (mif.mem_req === 1'b1) reqs++;
    tick();
    mif.mem_rvalid = 1; mif.mem_rdata = 64'hFFFF_FFFF_8765_4321;
    #1;
    if (mif.mem_req === 1'b1) reqs++;
    tick();
    n_checks++; if (valid_out !== 1'b1 || wreg_out !== 5'd8) begin n_fail++; $display("FAIL b2b_first_ctrl: got valid=%b wreg=%0d expected 1 8", valid_out, wreg_out); end
    n_checks++; if (mem_result_out !== 64'h0000_0000_8765_4321) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 0000000087654321", mem_result_out); end
    mif.mem_rvalid = 0;
    drive_load(2'b11, 1'b1, 5'd9, 64'h408);
    #1;
    if (mif.mem_req === 1'b1) reqs++;
    n_checks++; if (mif.mem_addr !== 64'h408) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 408", mif.mem_addr); end
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b expected 0", valid_out); end
    mif.mem_rvalid = 1; mif.mem_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    if (mif.mem_req === 1'b1) reqs++;
    tick();
    mif.mem_rvalid = 0;
    drive_idle();
    n_checks++; if (valid_out !== 1'b1 || wreg_out !== 5'd9) begin n_fail++; $display("FAIL b2b_second_ctrl: got valid=%b wreg=%0d expected 1 9", valid_out, wreg_out); end
    n_checks++; if (mem_result_out !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 0123456789abcdef", mem_result_out); end
    n_checks++; if (reqs !== 2) begin n_fail++; $display("FAIL b2b_req_pulses: got %0d expected 2", reqs); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_op();
    test_load_byte_sext();
    test_store_fwd();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
